reg_file: RTL and testbench

- Parametrised successor to the single bus register: a bank of NUM_REGS registers with one write port, two combinational read ports and a per-register busy scoreboard.
- Sits in the datapath in place of the individually instantiated general-purpose registers.
- Feeds operand A/B selection and lets control logic stall on registers that still have a pending writeback.

---
 rtl/reg_file_pkg.sv | 15 +
 rtl/reg_file_cell.sv | 45 ++++
 rtl/reg_file.sv | 92 +++++++++
 tb/tb_reg_file.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// reg_file shared types and default sizing.
// Bypass mode is enabled by defining REG_FILE_BYPASS_EN.
package reg_file_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_NUM_REGS   = 16;

  typedef logic [$clog2(DEF_NUM_REGS)-1:0] reg_addr_t;

  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0] value;
    logic                      busy;
  } reg_entry_t;

endpackage

// File: rtl/reg_file_cell.sv
// One register-file entry: stored value plus scoreboard busy bit.
// A same-edge busy set overrides the clear caused by the writeback.
module reg_file_cell
  import reg_file_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  we_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  set_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  busy_o
);

  logic [DATA_WIDTH-1:0] data_d, data_q;
  logic                  busy_d, busy_q;

  always_comb begin
    data_d = data_q;
    busy_d = busy_q;
    if (we_i) begin
      data_d = wdata_i;
      busy_d = 1'b0;
    end
    if (set_i) begin
      busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
      busy_q <= 1'b0;
    end else begin
      data_q <= data_d;
      busy_q <= busy_d;
    end
  end

  assign data_o = data_q;
  assign busy_o = busy_q;

endmodule

// File: rtl/reg_file.sv
// Register bank with one write port, two combinational read ports and
// a busy scoreboard. Define REG_FILE_BYPASS_EN for write-to-read bypass.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_REGS   = DEF_NUM_REGS,
  parameter int ZERO_REG   = 1,
  localparam int ADDR_WIDTH = $clog2(NUM_REGS)
) (
  input  logic                  clock,
  input  logic                  clear_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr_a,
  output logic [DATA_WIDTH-1:0] rd_data_a,
  input  logic [ADDR_WIDTH-1:0] rd_addr_b,
  output logic [DATA_WIDTH-1:0] rd_data_b,
  input  logic                  busy_set,
  input  logic [ADDR_WIDTH-1:0] busy_addr,
  output logic                  busy_a,
  output logic                  busy_b
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] NREGS_W =
    (ADDR_WIDTH+1)'(NUM_REGS);

  function automatic logic addr_ok(
    input logic [ADDR_WIDTH-1:0] a
  );
    logic zero_hit;
    zero_hit = (ZERO_REG != 0) && (a == '0);
    return ({1'b0, a} < NREGS_W) && !zero_hit;
  endfunction

  logic wr_ok, bs_ok;

  assign wr_ok = wr_en && addr_ok(wr_addr);
  assign bs_ok = busy_set && addr_ok(busy_addr);

  // Unused slots (zero reg, indices past NUM_REGS) read as constant 0.
  logic [DATA_WIDTH-1:0] data_arr [DEPTH];
  logic                  busy_arr [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_reg
    if (i >= NUM_REGS || (ZERO_REG != 0 && i == 0)) begin : g_tie
      assign data_arr[i] = '0;
      assign busy_arr[i] = 1'b0;
    end else begin : g_cell
      localparam logic [ADDR_WIDTH-1:0] IDX = ADDR_WIDTH'(i);
      reg_file_cell #(
        .DATA_WIDTH(DATA_WIDTH)
      ) u_cell (
        .clk_i  (clock),
        .rst_ni (clear_n),
        .we_i   (wr_ok && (wr_addr == IDX)),
        .wdata_i(wr_data),
        .set_i  (bs_ok && (busy_addr == IDX)),
        .data_o (data_arr[i]),
        .busy_o (busy_arr[i])
      );
    end
  end

  logic [ADDR_WIDTH-1:0] rd_addr [2];
  logic [DATA_WIDTH-1:0] rd_data [2];
  logic                  rd_busy [2];

  assign rd_addr[0] = rd_addr_a;
  assign rd_addr[1] = rd_addr_b;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data[p] = data_arr[rd_addr[p]];
      rd_busy[p] = busy_arr[rd_addr[p]];
`ifdef REG_FILE_BYPASS_EN
      if (wr_ok && (rd_addr[p] == wr_addr)) begin
        rd_data[p] = wr_data;
        rd_busy[p] = bs_ok && (busy_addr == wr_addr);
      end
`endif
    end
  end

  assign rd_data_a = rd_data[0];
  assign rd_data_b = rd_data[1];
  assign busy_a    = rd_busy[0];
  assign busy_b    = rd_busy[1];

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file (NUM_REGS=12, ZERO_REG=1).
// Honors REG_FILE_BYPASS_EN in its reference model.
module tb_reg_file;

  localparam int DW = 32;
  localparam int NR = 12;
  localparam int AW = 4;

  logic          clock;
  logic          clear_n;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] rd_addr_a;
  logic [DW-1:0] rd_data_a;
  logic [AW-1:0] rd_addr_b;
  logic [DW-1:0] rd_data_b;
  logic          busy_set;
  logic [AW-1:0] busy_addr;
  logic          busy_a;
  logic          busy_b;

  reg_file #(
    .DATA_WIDTH(DW),
    .NUM_REGS  (NR),
    .ZERO_REG  (1)
  ) dut (
    .clock    (clock),
    .clear_n  (clear_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_addr_a(rd_addr_a),
    .rd_data_a(rd_data_a),
    .rd_addr_b(rd_addr_b),
    .rd_data_b(rd_data_b),
    .busy_set (busy_set),
    .busy_addr(busy_addr),
    .busy_a   (busy_a),
    .busy_b   (busy_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0] mdata [16];
  bit            mbusy [16];

  function automatic bit valid_idx(input int a);
    return (a > 0) && (a < NR);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      mdata[i] = '0;
      mbusy[i] = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    if (!clear_n) begin
      model_reset();
    end else begin
      if (wr_en && valid_idx(int'(wr_addr))) begin
        mdata[wr_addr] = wr_data;
        mbusy[wr_addr] = 1'b0;
      end
      if (busy_set && valid_idx(int'(busy_addr)))
        mbusy[busy_addr] = 1'b1;
    end
    #1;
  endtask

  task automatic expect_port(
    input  logic [AW-1:0] a,
    output logic [DW-1:0] d,
    output logic          b
  );
    d = valid_idx(int'(a)) ? mdata[a] : '0;
    b = valid_idx(int'(a)) ? mbusy[a] : 1'b0;
`ifdef REG_FILE_BYPASS_EN
    if (clear_n && wr_en && valid_idx(int'(wr_addr)) && a == wr_addr) begin
      d = wr_data;
      b = busy_set && busy_addr == a;
    end
`endif
  endtask

  task automatic cmp(
    input string         tag,
    input logic [DW-1:0] obs,
    input logic [DW-1:0] exp
  );
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check(input string tag);
    logic [DW-1:0] ed;
    logic          eb;
    #1;
    expect_port(rd_addr_a, ed, eb);
    cmp({tag, ".data_a"}, rd_data_a, ed);
    cmp({tag, ".busy_a"}, {31'b0, busy_a}, {31'b0, eb});
    expect_port(rd_addr_b, ed, eb);
    cmp({tag, ".data_b"}, rd_data_b, ed);
    cmp({tag, ".busy_b"}, {31'b0, busy_b}, {31'b0, eb});
  endtask

  task automatic idle();
    wr_en = 1'b0;
    busy_set = 1'b0;
  endtask

  initial begin
    model_reset();
    clear_n = 1'b0;
    idle();
    wr_addr = '0;
    wr_data = '0;
    busy_addr = '0;
    rd_addr_a = 4'd5;
    rd_addr_b = 4'd7;
    check("reset");
    tick();
    clear_n = 1'b1;
    tick();

    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'hDEADBEEF;
    tick();
    idle();
    busy_set = 1'b1; busy_addr = 4'd5;
    tick();
    idle();
    rd_addr_a = 4'd5;
    check("r5_pre");
    clear_n = 1'b0;
    #1;
    model_reset();
    check("async_clear");
    clear_n = 1'b1;
    tick();

    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'h12345678;
    tick();
    idle();
    check("r5_write");

    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 32'hFFFFFFFF;
    busy_set = 1'b1; busy_addr = 4'd0;
    rd_addr_b = 4'd0;
    tick();
    idle();
    check("zero_reg");

    busy_set = 1'b1; busy_addr = 4'd7;
    tick();
    idle();
    rd_addr_a = 4'd7;
    check("sb_set");
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 32'hA5;
    tick();
    idle();
    check("sb_clear");
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 32'h5A;
    busy_set = 1'b1; busy_addr = 4'd7;
    tick();
    idle();
    check("sb_set_wins");

    wr_en = 1'b1; wr_addr = 4'd13; wr_data = 32'hCAFEF00D;
    busy_set = 1'b1; busy_addr = 4'd13;
    tick();
    idle();
    rd_addr_a = 4'd14;
    rd_addr_b = 4'd13;
    check("oor_read");
    for (int i = 0; i < NR; i += 2) begin
      rd_addr_a = AW'(i);
      rd_addr_b = AW'(i + 1);
      check("oor_scan");
    end
    tick();

    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'h55;
    tick();
    wr_en = 1'b1; wr_addr = 4'd4; wr_data = 32'h66;
    rd_addr_a = 4'd3;
    rd_addr_b = 4'd3;
    check("dual_same");
    tick();
    idle();
    rd_addr_b = 4'd4;
    check("dual_r4");

    wr_en = 1'b1; wr_addr = 4'd9; wr_data = 32'h11;
    tick();
    wr_en = 1'b1; wr_addr = 4'd9; wr_data = 32'h77;
    rd_addr_a = 4'd9;
    rd_addr_b = 4'd9;
    busy_set = 1'b1; busy_addr = 4'd9;
    check("bypass_set");
    busy_set = 1'b0;
    check("bypass");
    tick();
    idle();
    check("bypass_after");

    for (int n = 0; n < 300; n++) begin
      wr_en     = 1'($urandom_range(0, 1));
      wr_addr   = AW'($urandom_range(0, 15));
      wr_data   = $urandom;
      busy_set  = 1'($urandom_range(0, 1));
      busy_addr = AW'($urandom_range(0, 15));
      rd_addr_a = AW'($urandom_range(0, 15));
      rd_addr_b = ($urandom_range(0, 3) == 0) ? wr_addr
                                              : AW'($urandom_range(0, 15));
      check("random");
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
